// File: rtl/ram_loader.sv
// Program-RAM loader/arbiter: halts the CPU and streams 16 bytes into the RAM prog port.
// Optional LOADER_CHECKSUM_EN adds a CHECK state that verifies a trailing mod-256 sum byte.
module ram_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_w_en,
    input  logic [7:0]        cpu_w_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_w_en,
    output logic [7:0]        ram_w_data,
    output logic              ram_prog_mode,
    output logic [ADDR_W-1:0] ram_prog_addr,
    output logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [7:0]        data_q, data_d;
    logic              prog_q, prog_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              session;
    logic              accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    // in_ready is a pure function of state so there is no path from in_valid
    assign session  = (state_q != IDLE) && (state_q != DONE);
    assign in_ready = session;
    assign accept   = in_valid & session;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prog_addr_d = prog_addr_q;
        data_d      = data_q;
        prog_d      = 1'b0;
        done_d      = done_q;
        error_d     = error_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    done_d  = 1'b0;
                end else if (accept) begin
                    data_d      = in_data;
                    prog_addr_d = cnt_q;
                    prog_d      = 1'b1;
                    cnt_d       = cnt_q + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    sum_d       = sum_q + in_data;
                    if (cnt_q == LAST) state_d = CHECK;
`else
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                // trailing byte is compared only, never written to RAM
                if (abort) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    done_d  = 1'b0;
                end else if (accept) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    error_d = (in_data != sum_q);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prog_addr_q <= '0;
            data_q      <= 8'h00;
            prog_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prog_addr_q <= prog_addr_d;
            data_q      <= data_d;
            prog_q      <= prog_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // The final prog pulse can land in DONE, so CPU writes stay blocked while it is high
    assign ram_address   = cpu_addr;
    assign ram_w_en      = cpu_w_en & ~session & ~prog_q;
    assign ram_w_data    = prog_q ? data_q : cpu_w_data;
    assign ram_prog_mode = prog_q;
    assign ram_prog_addr = prog_addr_q;
    assign cpu_halt      = session;
    assign busy          = session;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: stimulus pushes expected prog writes, a negedge monitor pops them.
module tb_ram_loader;
    logic       clk = 1'b0;
    logic       rst, start, abort, in_valid, in_ready;
    logic [7:0] in_data;
    logic [3:0] cpu_addr;
    logic       cpu_w_en;
    logic [7:0] cpu_w_data;
    logic [3:0] ram_address, ram_prog_addr;
    logic       ram_w_en, ram_prog_mode, cpu_halt, busy, done, error;
    logic [7:0] ram_w_data;

    always #5 clk = ~clk;

    ram_loader #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_addr(cpu_addr), .cpu_w_en(cpu_w_en), .cpu_w_data(cpu_w_data),
        .ram_address(ram_address), .ram_w_en(ram_w_en), .ram_w_data(ram_w_data),
        .ram_prog_mode(ram_prog_mode), .ram_prog_addr(ram_prog_addr),
        .cpu_halt(cpu_halt), .busy(busy), .done(done), .error(error)
    );

    // behavioural 16x8 RAM with the prog port taking priority
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_prog_mode) mem[ram_prog_addr] <= ram_w_data;
        else if (ram_w_en) mem[ram_address] <= ram_w_data;
    end

    int          checks = 0;
    int          errors = 0;
    int          prog_cnt = 0;
    int          p0;
    logic [11:0] sb [$];
    logic [11:0] mon_e;
    logic [3:0]  exp_addr = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_prog_mode) begin
            prog_cnt++;
            if (sb.size() == 0) chk("unexpected_prog", 32'd1, 32'd0);
            else begin
                mon_e = sb.pop_front();
                chk("prog_write", {20'd0, ram_prog_addr, ram_w_data}, {20'd0, mon_e});
            end
        end
        if (cpu_halt || ram_prog_mode) chk("w_en_blocked", {31'd0, ram_w_en}, 32'd0);
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = 4'd0;
        @(negedge clk);
        chk("start_state", {27'd0, busy, cpu_halt, in_ready, done, error}, {27'd0, 5'b11100});
        @(posedge clk); #1;
    endtask

    // hold a byte until accepted; with abort set the byte is expected to be dropped
    task automatic send_byte(input logic [7:0] d, input bit push, input bit ab);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        abort    = ab;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
        else if (push && !ab) begin
            sb.push_back({exp_addr, d});
            exp_addr = exp_addr + 4'd1;
        end
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic chk_done(input logic e);
        in_valid = 1'b0;
        @(negedge clk);
        chk("done_state", {27'd0, done, error, busy, cpu_halt, in_ready}, {27'd0, 1'b1, e, 3'b000});
        @(posedge clk); #1;
    endtask

    task automatic chk_reset(input string name);
        @(negedge clk);
        chk(name, {22'd0, in_ready, cpu_halt, busy, done, error, ram_prog_mode, ram_prog_addr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        cpu_addr = 4'd0; cpu_w_en = 1'b0; cpu_w_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset("reset_values");

        // abort while idle leaves flags alone
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("idle_abort", {30'd0, error, busy}, 32'd0);

        // pass-through
        @(posedge clk); #1;
        cpu_w_en = 1'b1; cpu_addr = 4'd3; cpu_w_data = 8'h5A;
        #1;
        chk("passthrough", {17'd0, ram_w_en, ram_address, ram_w_data, cpu_halt, ram_prog_mode},
            {17'd0, 1'b1, 4'd3, 8'h5A, 1'b0, 1'b0});
        @(posedge clk); #1 cpu_w_en = 1'b0;
        chk("cpu_write_mem3", {24'd0, mem[3]}, 32'h5A);

        // back-to-back load 0x00..0x0F
        p0 = prog_cnt;
        do_start();
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h78, 1'b0, 1'b0);
`endif
        chk_done(1'b0);
        chk("b2b_prog_count", prog_cnt - p0, 32'd16);
        chk("b2b_sb_empty", sb.size(), 32'd0);
        cpu_addr = 4'd7;
        #1;
        chk("readback_addr", {28'd0, ram_address}, 32'd7);
        chk("readback_data", {24'd0, mem[ram_address]}, 32'h07);

        // gapped load with CPU trying to write throughout
        p0 = prog_cnt;
        do_start();
        cpu_w_en = 1'b1; cpu_addr = 4'd9; cpu_w_data = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'hA0 + i), 1'b1, 1'b0);
            if (i == 15) cpu_w_en = 1'b0;
            else begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h78, 1'b0, 1'b0);
`endif
        chk_done(1'b0);
        chk("gap_prog_count", prog_cnt - p0, 32'd16);
        for (int i = 0; i < 16; i++) chk("gap_mem", {24'd0, mem[i]}, 32'(8'hA0 + i));

        // abort after 5 bytes, sixth byte accepted on the abort edge is dropped
        do_start();
        for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i), 1'b1, 1'b0);
        send_byte(8'h55, 1'b0, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_state", {28'd0, busy, error, done, ram_prog_mode}, {28'd0, 4'b0100});
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) chk("abort_mem_written", {24'd0, mem[i]}, 32'(8'h50 + i));
        for (int i = 5; i < 16; i++) chk("abort_mem_kept", {24'd0, mem[i]}, 32'(8'hA0 + i));

        // restart from address 0, then reset mid-session
        do_start();
        for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i), 1'b1, 1'b0);
        rst = 1'b1; start = 1'b1; in_data = 8'hEE;
        @(posedge clk); #1;
        chk_reset("rst_midload");
        @(posedge clk); #1;
        chk_reset("rst_held");
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mem7", {24'd0, mem[7]}, 32'h37);
        chk("rst_mem8", {24'd0, mem[8]}, 32'hA8);
        chk("rst_sb_empty", sb.size(), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        do_start();
        for (int i = 0; i < 16; i++) send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h10, 1'b0, 1'b0);
        chk_done(1'b0);
        do_start();
        for (int i = 0; i < 16; i++) send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        chk_done(1'b1);
        chk("cksum_mem_kept", {24'd0, mem[12]}, 32'h01);
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
